// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, sequences the system reset release and generates the
// 1 us / 1 ms timebase strobes while the fabric is running.
module pll_reset_sequencer #(
  parameter int unsigned CLK_HZ             = 48000000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES        = 4800,
  parameter int unsigned MS_DIV             = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       sys_rst_n,
  output logic       tick_1us,
  output logic       tick_1ms,
  output logic       lock_lost,
  output logic [1:0] state
);

  localparam int unsigned US_DIV  = CLK_HZ / 1000000;
  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                       : HOLD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned US_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned MS_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [US_W-1:0]  US_LAST     = US_W'(US_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST     = MS_W'(MS_DIV - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StStable   = 2'd1,
    StHold     = 2'd2,
    StRun      = 2'd3
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [US_W-1:0]  us_cnt_q;
  logic [MS_W-1:0]  ms_cnt_q;
  logic             lock_s;

  assign lock_s = sync_q[1];
  assign state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWaitLock;
      sync_q    <= 2'b00;
      cnt_q     <= '0;
      us_cnt_q  <= '0;
      ms_cnt_q  <= '0;
      sys_rst_n <= 1'b0;
      tick_1us  <= 1'b0;
      tick_1ms  <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pll_lock};
      // Timebase is forced idle unless RUN continues below.
      us_cnt_q <= '0;
      ms_cnt_q <= '0;
      tick_1us <= 1'b0;
      tick_1ms <= 1'b0;
      unique case (state_q)
        StWaitLock: begin
          if (lock_s) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end
        end
        StStable: begin
          if (!lock_s) begin
            state_q <= StWaitLock;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StHold: begin
          if (!lock_s) begin
            state_q <= StWaitLock;
          end else if (cnt_q == HOLD_LAST) begin
            state_q   <= StRun;
            sys_rst_n <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_q   <= StWaitLock;
            sys_rst_n <= 1'b0;
            lock_lost <= 1'b1;
          end else if (us_cnt_q == US_LAST) begin
            tick_1us <= 1'b1;
            if (ms_cnt_q == MS_LAST) begin
              tick_1ms <= 1'b1;
            end else begin
              ms_cnt_q <= ms_cnt_q + MS_W'(1);
            end
          end else begin
            us_cnt_q <= us_cnt_q + US_W'(1);
            ms_cnt_q <= ms_cnt_q;
          end
        end
        default: state_q <= StWaitLock;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock patterns, every cycle
// compared against a model based on the length of the current run of synchronized lock.
module tb_pll_reset_sequencer;

  localparam int unsigned L      = 8;
  localparam int unsigned H      = 16;
  localparam int unsigned CLKHZ  = 48000000;
  localparam int unsigned MSD    = 4;
  localparam int          US     = 48;
  localparam int          MSP    = US * MSD;
  localparam int          RUN_AT = L + H + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       sys_rst_n;
  logic       tick_1us;
  logic       tick_1ms;
  logic       lock_lost;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Model: two-stage sync pipeline and the count of consecutive synchronized-high cycles.
  bit s1 = 1'b0;
  bit s2 = 1'b0;
  bit lost = 1'b0;
  int run_len = 0;

  pll_reset_sequencer #(
    .CLK_HZ            (CLKHZ),
    .LOCK_STABLE_CYCLES(L),
    .HOLD_CYCLES       (H),
    .MS_DIV            (MSD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .sys_rst_n(sys_rst_n),
    .tick_1us (tick_1us),
    .tick_1ms (tick_1ms),
    .lock_lost(lock_lost),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    s1 = 1'b0;
    s2 = 1'b0;
    lost = 1'b0;
    run_len = 0;
  endtask

  function automatic logic [7:0] exp_state();
    if (run_len == 0) return 8'd0;
    if (run_len <= L) return 8'd1;
    if (run_len <= L + H) return 8'd2;
    return 8'd3;
  endfunction

  task automatic check_all(input string tag);
    int k;
    k = run_len - RUN_AT;
    chk({tag, ".sys_rst_n"}, 8'(sys_rst_n), 8'(run_len >= RUN_AT));
    chk({tag, ".tick_1us"}, 8'(tick_1us), 8'(k > 0 && (k % US) == 0));
    chk({tag, ".tick_1ms"}, 8'(tick_1ms), 8'(k > 0 && (k % MSP) == 0));
    chk({tag, ".lock_lost"}, 8'(lock_lost), 8'(lost));
    chk({tag, ".state"}, 8'(state), exp_state());
  endtask

  // One clock: model samples on the rising edge, DUT compared on the falling edge.
  task automatic step(input string tag);
    bit seen;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      seen = s2;
      if (!seen && run_len >= RUN_AT) lost = 1'b1;
      run_len = seen ? run_len + 1 : 0;
      s2 = s1;
      s1 = pll_lock;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int n_us;
    int n_ms;
    logic saw_high;

    // 1: reset held with lock high, then release and measure latency.
    pll_lock = 1'b1;
    #1 check_all("por");
    steps(4, "por");
    rst_n = 1'b1;
    steps(26, "lat");
    chk("lat_edge26", 8'(sys_rst_n), 8'd0);
    step("lat");
    chk("lat_edge27", 8'(sys_rst_n), 8'd1);

    // 3: timebase in RUN.
    n_us = 0;
    n_ms = 0;
    for (int i = 0; i < 400; i++) begin
      step("run");
      n_us += int'(tick_1us);
      n_ms += int'(tick_1ms);
    end
    chk("run_us_count", 8'(n_us), 8'(400 / US));
    chk("run_ms_count", 8'(n_ms), 8'(400 / MSP));

    // 4: lock drop in RUN, then re-lock; lock_lost must stick.
    pll_lock = 1'b0;
    steps(2, "drop");
    chk("drop_edge2", 8'(sys_rst_n), 8'd1);
    step("drop");
    chk("drop_edge3", 8'(sys_rst_n), 8'd0);
    chk("drop_lost", 8'(lock_lost), 8'd1);
    steps(3, "drop");
    pll_lock = 1'b1;
    steps(30, "relock");
    chk("relock_run", 8'(sys_rst_n), 8'd1);
    chk("relock_lost", 8'(lock_lost), 8'd1);

    // 2: one-cycle low seen in STABLE at cnt=5.
    pll_lock = 1'b0;
    steps(5, "glitch");
    pll_lock = 1'b1;
    steps(6, "glitch");
    pll_lock = 1'b0;
    step("glitch");
    pll_lock = 1'b1;
    step("glitch");
    chk("glitch_pre", 8'(state), 8'd1);
    step("glitch");
    chk("glitch_restart", 8'(state), 8'd0);
    steps(30, "glitch_relock");

    // 5: lock loss coinciding with HOLD terminal count.
    pll_lock = 1'b0;
    steps(5, "holdterm");
    pll_lock = 1'b1;
    saw_high = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step("holdterm");
      saw_high |= sys_rst_n;
    end
    pll_lock = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step("holdterm");
      saw_high |= sys_rst_n;
    end
    chk("holdterm_norun", 8'(saw_high), 8'd0);
    chk("holdterm_state", 8'(state), 8'd0);

    // 6: asynchronous reset in the middle of RUN with lock_lost set.
    pll_lock = 1'b1;
    steps(80, "prerst");
    #7 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    chk("async_rst_lost", 8'(lock_lost), 8'd0);
    @(negedge clk);
    steps(3, "in_rst");
    rst_n = 1'b1;

    // Random lock patterns.
    for (int r = 0; r < 25; r++) begin
      pll_lock = 1'b1;
      steps(int'($urandom_range(1, 250)), "rand_hi");
      pll_lock = 1'b0;
      steps(int'($urandom_range(1, 4)), "rand_lo");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
